// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic_mm_stream matrix multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Cycles needed after the last beat for it to reach the far corner PE.
  function automatic int flush_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Width of a counter that must hold 0..k_max inclusive.
  function automatic int kcnt_width(input int k_max);
    return $clog2(k_max + 1);
  endfunction

endpackage

// File: rtl/mac_pe.sv
// One output-stationary processing element: forwards a right and b down by one
// register each, and accumulates a*b whenever both incoming operands are tagged
// valid. Build option SYSTOLIC_SIGNED_EN selects two's-complement operands.
module mac_pe
  import systolic_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  a,
  input  logic                 a_vld,
  input  logic [IN_WIDTH-1:0]  b,
  input  logic                 b_vld,
  output logic [IN_WIDTH-1:0]  a_fwd,
  output logic                 a_vld_fwd,
  output logic [IN_WIDTH-1:0]  b_fwd,
  output logic                 b_vld_fwd,
  output logic [OUT_WIDTH-1:0] acc
);

  logic [OUT_WIDTH-1:0] prod_ext;

`ifdef SYSTOLIC_SIGNED_EN
  logic signed [2*IN_WIDTH-1:0] prod_s;

  // Signed product, sign-extended to the accumulator width.
  always_comb begin
    prod_s   = $signed(a) * $signed(b);
    prod_ext = OUT_WIDTH'(prod_s);
  end
`else
  logic [2*IN_WIDTH-1:0] prod_u;

  // Unsigned product, zero-extended to the accumulator width.
  always_comb begin
    prod_u   = a * b;
    prod_ext = OUT_WIDTH'(prod_u);
  end
`endif

  // Operand forwarding and tagged multiply-accumulate (wraps modulo 2^OUT_WIDTH).
  // NOTE: sequential state uses non-blocking assignments so every PE samples its
  // neighbours' pre-edge values; blocking here would collapse the pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_fwd     <= '0;
      a_vld_fwd <= 1'b0;
      b_fwd     <= '0;
      b_vld_fwd <= 1'b0;
      acc       <= '0;
    end else if (clear) begin
      a_fwd     <= '0;
      a_vld_fwd <= 1'b0;
      b_fwd     <= '0;
      b_vld_fwd <= 1'b0;
      acc       <= '0;
    end else begin
      a_fwd     <= a;
      a_vld_fwd <= a_vld;
      b_fwd     <= b;
      b_vld_fwd <= b_vld;
      if (a_vld && b_vld) acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_mm_stream.sv
// ROWS x COLS output-stationary systolic matrix multiplier with run-time K,
// built-in operand skew, valid/ready input beats and a held, handshaked result.
// Build option SYSTOLIC_SIGNED_EN (see mac_pe) selects signed arithmetic.
module systolic_mm_stream
  import systolic_pkg::*;
#(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter int K_MAX     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [kcnt_width(K_MAX)-1:0]  k_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_WIDTH-1:0]           a_in [0:ROWS-1],
  input  logic [IN_WIDTH-1:0]           b_in [0:COLS-1],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out [0:ROWS-1][0:COLS-1],
  output logic                          busy
);

  localparam int              KW         = kcnt_width(K_MAX);
  localparam int              FLUSH_N    = flush_cycles(ROWS, COLS);
  localparam int              FW         = $clog2(FLUSH_N + 1);
  localparam logic [KW-1:0]   K_MAX_C    = KW'(K_MAX);
  localparam logic [FW-1:0]   FLUSH_LAST = FW'(FLUSH_N - 1);

  typedef struct packed {
    logic                vld;
    logic [IN_WIDTH-1:0] data;
  } opnd_t;

  state_e          state, state_nxt;
  logic [KW-1:0]   k_eff, k_lat, beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic            clear, beat_acc;

  assign k_eff    = (k_len > K_MAX_C) ? K_MAX_C : k_len;
  assign clear    = (state == IDLE) && start;
  assign beat_acc = (state == LOAD) && in_valid;
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (k_eff == '0) ? DONE : LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (beat_cnt == k_lat - KW'(1))) state_nxt = FLUSH;
      end
      FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job length latch, accepted-beat counter and flush timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_lat     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (clear) begin
        k_lat    <= k_eff;
        beat_cnt <= '0;
      end else if (beat_acc) begin
        beat_cnt <= beat_cnt + KW'(1);
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
    end
  end

  // Operand mesh: index [row][col]; column COLS / row ROWS are the far edges.
  logic [IN_WIDTH-1:0] a_pipe  [ROWS][COLS+1];
  logic                a_vpipe [ROWS][COLS+1];
  logic [IN_WIDTH-1:0] b_pipe  [ROWS+1][COLS];
  logic                b_vpipe [ROWS+1][COLS];

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    opnd_t sr [0:gi];

    // Row gi of A: capture the beat with its tag, then delay gi more cycles.
    // NOTE: the skew stages are reset and cleared because their valid tags
    // decide whether a PE accumulates; stale tags would corrupt the next job.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset || clear) begin
        for (int d = 0; d <= gi; d++) sr[d] <= '0;
      end else begin
        sr[0] <= '{vld: beat_acc, data: a_in[gi]};
        for (int d = 1; d <= gi; d++) sr[d] <= sr[d-1];
      end
    end

    assign a_pipe[gi][0]  = sr[gi].data;
    assign a_vpipe[gi][0] = sr[gi].vld;
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
    opnd_t sr [0:gj];

    // Column gj of B: capture the beat with its tag, then delay gj more cycles.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset || clear) begin
        for (int d = 0; d <= gj; d++) sr[d] <= '0;
      end else begin
        sr[0] <= '{vld: beat_acc, data: b_in[gj]};
        for (int d = 1; d <= gj; d++) sr[d] <= sr[d-1];
      end
    end

    assign b_pipe[0][gj]  = sr[gj].data;
    assign b_vpipe[0][gj] = sr[gj].vld;
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      mac_pe #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
      ) u_pe (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .a         (a_pipe[gi][gj]),
        .a_vld     (a_vpipe[gi][gj]),
        .b         (b_pipe[gi][gj]),
        .b_vld     (b_vpipe[gi][gj]),
        .a_fwd     (a_pipe[gi][gj+1]),
        .a_vld_fwd (a_vpipe[gi][gj+1]),
        .b_fwd     (b_pipe[gi+1][gj]),
        .b_vld_fwd (b_vpipe[gi+1][gj]),
        .acc       (out[gi][gj])
      );
    end
  end

  // Operands leaving the far edges of the mesh have no consumer.
  logic unused_edge;
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < ROWS; i++) unused_edge = unused_edge ^ (^a_pipe[i][COLS]) ^ a_vpipe[i][COLS];
    for (int j = 0; j < COLS; j++) unused_edge = unused_edge ^ (^b_pipe[ROWS][j]) ^ b_vpipe[ROWS][j];
  end

endmodule

// File: tb/tb_systolic_mm_stream.sv
// Self-checking bench for systolic_mm_stream: directed jobs plus randomized
// operands, compared against a plain matrix-product reference model.
// Honours SYSTOLIC_SIGNED_EN the same way as the design.
module tb_systolic_mm_stream;
  localparam int ROWS      = 3;
  localparam int COLS      = 3;
  localparam int IN_WIDTH  = 8;
  localparam int OUT_WIDTH = 32;
  localparam int K_MAX     = 16;
  localparam int KW        = $clog2(K_MAX + 1);

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  a_in [0:ROWS-1];
  logic [IN_WIDTH-1:0]  b_in [0:COLS-1];
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_m [0:ROWS-1][0:COLS-1];
  logic                 busy;

  systolic_mm_stream #(
    .ROWS(ROWS), .COLS(COLS), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .K_MAX(K_MAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_m), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Operand matrices for the current job: A is ROWS x K, B is K x COLS.
  logic [IN_WIDTH-1:0] ma [0:ROWS-1][0:K_MAX-1];
  logic [IN_WIDTH-1:0] mb [0:K_MAX-1][0:COLS-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], modulo 2^OUT_WIDTH.
  function automatic logic [OUT_WIDTH-1:0] model_c(input int i, input int j, input int kk);
    longint s = 0;
    for (int k = 0; k < kk; k++) begin
`ifdef SYSTOLIC_SIGNED_EN
      s += longint'($signed(ma[i][k])) * longint'($signed(mb[k][j]));
`else
      s += longint'(ma[i][k]) * longint'(mb[k][j]);
`endif
    end
    return OUT_WIDTH'(s);
  endfunction

  task automatic fill_random();
    for (int k = 0; k < K_MAX; k++) begin
      for (int i = 0; i < ROWS; i++) ma[i][k] = IN_WIDTH'($urandom);
      for (int j = 0; j < COLS; j++) mb[k][j] = IN_WIDTH'($urandom);
    end
  endtask

  task automatic drive_junk();
    for (int i = 0; i < ROWS; i++) a_in[i] = IN_WIDTH'($urandom);
    for (int j = 0; j < COLS; j++) b_in[j] = IN_WIDTH'($urandom);
  endtask

  // Run one job from IDLE; called #1 after a rising edge.
  task automatic do_job(input string name, input int kl, input bit bubbles, input int hold);
    int  kk, beat, cyc, lat, exp_lat;
    bit  will_acc, tog;
    kk = (kl > K_MAX) ? K_MAX : kl;
    exp_lat = (kk == 0) ? 1 : kk + ROWS + COLS + (bubbles ? kk : 0);
    start = 1'b1; k_len = KW'(kl); in_valid = 1'b0; out_ready = 1'b0;
    drive_junk();
    beat = 0; cyc = 0; lat = -1; tog = 1'b0;
    while (cyc < 300 && lat < 0) begin
      will_acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (will_acc) beat++;
      if (out_valid) begin
        lat = cyc;
        in_valid = 1'b0;
      end else if (in_ready && beat < kk) begin
        in_valid = bubbles ? tog : 1'b1;
        tog = ~tog;
        if (in_valid) begin
          for (int i = 0; i < ROWS; i++) a_in[i] = ma[i][beat];
          for (int j = 0; j < COLS; j++) b_in[j] = mb[beat][j];
        end else begin
          drive_junk();
        end
      end else begin
        // Past the last beat: keep offering junk on clamped jobs; it must be refused.
        in_valid = (kl > K_MAX);
        drive_junk();
      end
    end
    in_valid = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_beats"}, 64'(beat), 64'(kk));
    check({name, "_busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        check($sformatf("%s_c%0d%0d", name, i, j), 64'(out_m[i][j]), 64'(model_c(i, j, kk)));
    // Consumer stall: result must hold, start pulses must be ignored.
    for (int h = 0; h < hold; h++) begin
      start = (h % 2 == 0); k_len = KW'(1);
      @(posedge clk); #1;
      check($sformatf("%s_hold_valid%0d", name, h), 64'(out_valid), 64'd1);
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          check($sformatf("%s_hold_c%0d%0d", name, i, j), 64'(out_m[i][j]), 64'(model_c(i, j, kk)));
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_post_valid"}, 64'(out_valid), 64'd0);
    check({name, "_post_busy"}, 64'(busy), 64'd0);
    check({name, "_post_retain"}, 64'(out_m[ROWS-1][COLS-1]), 64'(model_c(ROWS-1, COLS-1, kk)));
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_in_ready"}, 64'(in_ready), 64'd0);
    check({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        check($sformatf("%s_out%0d%0d", name, i, j), 64'(out_m[i][j]), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
    drive_junk();
    #12;
    check_reset_state("rst");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Identity A times B = [1..9].
    for (int k = 0; k < K_MAX; k++) begin
      for (int i = 0; i < ROWS; i++) ma[i][k] = (i == k) ? 8'd1 : 8'd0;
      for (int j = 0; j < COLS; j++) mb[k][j] = IN_WIDTH'(k * COLS + j + 1);
    end
    do_job("ident", 3, 1'b0, 0);

    // Empty job.
    fill_random();
    do_job("k0", 0, 1'b0, 0);

    // Bubbles every other cycle.
    fill_random();
    do_job("bubble", 4, 1'b1, 0);

    // Consumer stalls for 10 cycles.
    fill_random();
    do_job("stall", 5, 1'b0, 10);

    // Reset in the middle of a load, then a clean all-ones job.
    fill_random();
    start = 1'b1; k_len = KW'(4);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; drive_junk();
    @(posedge clk); #1;
    drive_junk();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    in_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < K_MAX; k++) begin
      for (int i = 0; i < ROWS; i++) ma[i][k] = 8'd1;
      for (int j = 0; j < COLS; j++) mb[k][j] = 8'd1;
    end
    do_job("ones", 2, 1'b0, 0);
    check("ones_direct", 64'(out_m[1][1]), 64'd2);

    // Sign handling: a = -1 / 255, b = 3, K = 2.
    for (int k = 0; k < K_MAX; k++) begin
      for (int i = 0; i < ROWS; i++) ma[i][k] = 8'hFF;
      for (int j = 0; j < COLS; j++) mb[k][j] = 8'd3;
    end
    do_job("sign", 2, 1'b0, 0);
`ifdef SYSTOLIC_SIGNED_EN
    check("sign_direct", 64'(out_m[0][0]), 64'h0000_0000_FFFF_FFFA);
`else
    check("sign_direct", 64'(out_m[0][0]), 64'd1530);
`endif

    // k_len above K_MAX is clamped; extra beats are refused.
    fill_random();
    do_job("clamp", 20, 1'b0, 0);

    // Random jobs with random length and gap pattern.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      do_job($sformatf("rand%0d", r), int'($urandom_range(1, K_MAX)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
